fifo_uart_tx: RTL and testbench

//  Read-side consumer of the 8-entry FIFO: pops words while the FIFO is non-empty and

---
 rtl/fifo_uart_pkg.sv | 23 ++
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/uart_baud_counter.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 131 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    // Transmitter sequencing states; WAIT and PARITY are only reached in some builds
    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Counter width for a modulus n, never narrower than one bit
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of the FIFO as seen by its consumer.
// master: the consumer issuing pops; slave: the FIFO answering them.
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_Empty;
    logic [DATA_WIDTH-1:0] fifo_Data;
    logic                  fifo_Read_Enable;

    modport master (
        output fifo_Read_Enable,
        input  fifo_Empty,
        input  fifo_Data
    );

    modport slave (
        input  fifo_Read_Enable,
        output fifo_Empty,
        output fifo_Data
    );
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared.
// bit_tick is registered and is high during the last cycle of each bit period.
module uart_baud_counter
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = width_of(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             bit_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_nxt;

    // Wrap at the bit boundary
    always_comb begin
        count_nxt = count + CNT_W'(1);
        if (count == LAST) begin
            count_nxt = '0;
        end
    end

    // Counter and look-ahead tick so the tick lines up with count==LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            bit_tick <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            bit_tick <= 1'b0;
        end else begin
            count    <= count_nxt;
            bit_tick <= (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame and sends
// start, DATA_WIDTH bits LSB-first, optional even parity, stop.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT      = 16,
    parameter int unsigned FIFO_READ_LATENCY = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_Enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx_Serial,
    output logic                  tx_Busy,
    output logic                  tx_Done
);

    localparam int unsigned CNT_W = width_of(CLKS_PER_BIT);
    localparam int unsigned IDX_W = width_of(DATA_WIDTH);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift;
    logic [IDX_W-1:0]      bit_idx;
    logic [CNT_W-1:0]      baud_cnt;
    logic                  bit_tick;
    logic                  baud_clear;

    // Baud timing runs only while a bit is on the line
    assign baud_clear = (state == IDLE) || (state == POP) || (state == WAIT);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk      (clock),
        .rst_n    (reset),
        .clear    (baud_clear),
        .count    (baud_cnt),
        .bit_tick (bit_tick)
    );

    // Frame sequencer with registered line, pop strobe and status
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            shift                 <= '0;
            bit_idx               <= '0;
            tx_Serial             <= LINE_IDLE;
            tx_Busy               <= 1'b0;
            tx_Done               <= 1'b0;
            fifo.fifo_Read_Enable <= 1'b0;
        end else begin
            fifo.fifo_Read_Enable <= 1'b0;
            tx_Done               <= 1'b0;
            case (state)
                IDLE: begin
                    tx_Serial <= LINE_IDLE;
                    bit_idx   <= '0;
                    if (tx_Enable && !fifo.fifo_Empty) begin
                        state                 <= POP;
                        fifo.fifo_Read_Enable <= 1'b1;
                        tx_Busy               <= 1'b1;
                    end
                end
                POP: begin
                    if (FIFO_READ_LATENCY == 0) begin
                        shift     <= fifo.fifo_Data;
                        tx_Serial <= LINE_START;
                        state     <= START;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    shift     <= fifo.fifo_Data;
                    tx_Serial <= LINE_START;
                    state     <= START;
                end
                START: begin
                    if (bit_tick) begin
                        tx_Serial <= shift[0];
                        bit_idx   <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            tx_Serial <= ^shift;
                            state     <= PARITY;
`else
                            tx_Serial <= LINE_IDLE;
                            state     <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            tx_Serial <= shift[bit_idx + IDX_W'(1)];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx_Serial <= LINE_IDLE;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (baud_cnt == DONE_CNT) begin
                        tx_Done <= 1'b1;
                    end
                    if (bit_tick) begin
                        tx_Busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    tx_Serial <= LINE_IDLE;
                    tx_Busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one show-ahead instance and one registered-read instance.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx_en = 1'b0;

    always #5 clock = ~clock;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) f0 ();
    fifo_uart_tx_if #(.DATA_WIDTH(DW)) f1 ();

    logic tx0, busy0, done0;
    logic tx1, busy1, done1;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_READ_LATENCY(0)) u_dut0 (
        .clock(clock), .reset(reset), .tx_Enable(tx_en), .fifo(f0),
        .tx_Serial(tx0), .tx_Busy(busy0), .tx_Done(done0)
    );

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_READ_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .tx_Enable(tx_en), .fifo(f1),
        .tx_Serial(tx1), .tx_Busy(busy1), .tx_Done(done1)
    );

    // FIFO models: pointers, writes from the test process, pops from the DUT strobe
    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    logic [5:0] wr0 = '0, rd0 = '0, wr1 = '0, rd1 = '0;
    logic [7:0] data1 = '0;
    int underflow = 0;

    assign f0.fifo_Empty = (rd0 == wr0);
    assign f0.fifo_Data  = mem0[rd0];
    assign f1.fifo_Empty = (rd1 == wr1);
    assign f1.fifo_Data  = data1;

    always @(posedge clock) begin
        if (f0.fifo_Read_Enable) rd0 <= rd0 + 6'd1;
        if (f1.fifo_Read_Enable) begin
            data1 <= mem1[rd1];
            rd1   <= rd1 + 6'd1;
        end
        if ((f0.fifo_Read_Enable && f0.fifo_Empty) || (f1.fifo_Read_Enable && f1.fifo_Empty))
            underflow <= underflow + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic push0(input logic [7:0] d);
        mem0[wr0] = d;
        wr0 = wr0 + 6'd1;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wr1] = d;
        wr1 = wr1 + 6'd1;
    endtask

    function automatic logic line_of(input int sel);
        return (sel == 0) ? tx0 : tx1;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    // Expected line level for each cycle of a frame carrying d
    function automatic logic [43:0] exp_line(input logic [7:0] d);
        logic [15:0] b;
        logic [43:0] v;
        b = '0;
        b[0] = 1'b0;
        b[8:1] = d;
`ifdef UART_TX_PARITY_EN
        b[9] = ^d;
`endif
        b[4'(FRAME_BITS - 1)] = 1'b1;
        v = '0;
        for (int c = 0; c < FRAME_CYC; c++) v[6'(c)] = b[4'(c / CPB)];
        return v;
    endfunction

    // Waits (bounded) for a start bit then records one frame of line samples
    task automatic capture_frame(input int sel, input int drop_at, output logic [43:0] line,
                                 output int gap, output int done_pos, output int done_cnt,
                                 output bit ok);
        gap = 0; ok = 1'b0; line = '0; done_pos = -1; done_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (line_of(sel) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            gap++;
        end
        if (!ok) return;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clock);
            line[6'(c)] = line_of(sel);
            if (done_of(sel)) begin
                done_cnt++;
                done_pos = c;
            end
            if (c == drop_at) tx_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_en = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1", tx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (f0.fifo_Read_Enable !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", f0.fifo_Read_Enable); end
        checks++; if (done0 !== 1'b0 || tx1 !== 1'b1) begin errors++; $display("FAIL reset_done_line1: got done=%b tx1=%b expected 0/1", done0, tx1); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_word();
        logic [43:0] line; int gap, dp, dc; bit ok; logic [5:0] rs;
        rs = rd0;
        push0(8'hA5);
        tx_en = 1'b1;
        capture_frame(0, -1, line, gap, dp, dc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no start bit expected start within 200 cycles"); end
        checks++; if (line !== exp_line(8'hA5)) begin errors++; $display("FAIL single_line: got %h expected %h", line, exp_line(8'hA5)); end
        checks++; if (dc != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", dc); end
        checks++; if (dp != FRAME_CYC - 1) begin errors++; $display("FAIL single_done_pos: got %0d expected %0d", dp, FRAME_CYC - 1); end
        repeat (4) @(negedge clock);
        checks++; if (6'(rd0 - rs) !== 6'd1) begin errors++; $display("FAIL single_pops: got %0d expected 1", 6'(rd0 - rs)); end
        checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin errors++; $display("FAIL single_idle: got busy=%b line=%b expected 0/1", busy0, tx0); end
    endtask

    task automatic test_back_to_back();
        logic [43:0] line; int gap, dp, dc; bit ok;
        push0(8'h00); push0(8'hFF);
        capture_frame(0, -1, line, gap, dp, dc, ok);
        checks++; if (!ok || line !== exp_line(8'h00)) begin errors++; $display("FAIL b2b_lat0_first: got ok=%b %h expected %h", ok, line, exp_line(8'h00)); end
        capture_frame(0, -1, line, gap, dp, dc, ok);
        checks++; if (!ok || line !== exp_line(8'hFF)) begin errors++; $display("FAIL b2b_lat0_second: got ok=%b %h expected %h", ok, line, exp_line(8'hFF)); end
        checks++; if (gap != 2) begin errors++; $display("FAIL b2b_lat0_gap: got %0d expected 2", gap); end
        push1(8'h00); push1(8'hFF);
        capture_frame(1, -1, line, gap, dp, dc, ok);
        checks++; if (!ok || line !== exp_line(8'h00)) begin errors++; $display("FAIL b2b_lat1_first: got ok=%b %h expected %h", ok, line, exp_line(8'h00)); end
        capture_frame(1, -1, line, gap, dp, dc, ok);
        checks++; if (!ok || line !== exp_line(8'hFF)) begin errors++; $display("FAIL b2b_lat1_second: got ok=%b %h expected %h", ok, line, exp_line(8'hFF)); end
        checks++; if (gap != 3) begin errors++; $display("FAIL b2b_lat1_gap: got %0d expected 3", gap); end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_empty_idle();
        int rden_hi, line_lo;
        rden_hi = 0; line_lo = 0;
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (f0.fifo_Read_Enable || f1.fifo_Read_Enable) rden_hi++;
            if (tx0 !== 1'b1 || tx1 !== 1'b1 || busy0 || busy1) line_lo++;
        end
        checks++; if (rden_hi != 0) begin errors++; $display("FAIL empty_rden: got %0d pops expected 0", rden_hi); end
        checks++; if (line_lo != 0) begin errors++; $display("FAIL empty_line: got %0d active cycles expected 0", line_lo); end
    endtask

    task automatic test_enable_drop();
        logic [43:0] line; int gap, dp, dc; bit ok; logic [5:0] rs; int active;
        rs = rd0;
        push0(8'h3C); push0(8'h5A);
        tx_en = 1'b1;
        capture_frame(0, 17, line, gap, dp, dc, ok);
        checks++; if (!ok || line !== exp_line(8'h3C)) begin errors++; $display("FAIL drop_line: got ok=%b %h expected %h", ok, line, exp_line(8'h3C)); end
        active = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (tx0 !== 1'b1 || f0.fifo_Read_Enable) active++;
        end
        checks++; if (active != 0) begin errors++; $display("FAIL drop_quiet: got %0d active cycles expected 0", active); end
        checks++; if (6'(rd0 - rs) !== 6'd1) begin errors++; $display("FAIL drop_pops: got %0d expected 1", 6'(rd0 - rs)); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", busy0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [43:0] line; int gap, dp, dc; bit ok; logic [5:0] rs; int bad;
        rs = rd0;
        push0(8'hC3);
        tx_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (tx0 == 1'b0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_start: got no start bit expected start within 200 cycles"); end
        repeat (20) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0 || f0.fifo_Read_Enable !== 1'b0) begin
            errors++; $display("FAIL rst_mid_immediate: got line=%b busy=%b rden=%b expected 1/0/0", tx0, busy0, f0.fifo_Read_Enable); end
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || f0.fifo_Read_Enable !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_hold: got %0d bad cycles expected 0", bad); end
        reset = 1'b1;
        capture_frame(0, -1, line, gap, dp, dc, ok);
        checks++; if (!ok || line !== exp_line(8'hC3)) begin errors++; $display("FAIL rst_mid_next: got ok=%b %h expected %h", ok, line, exp_line(8'hC3)); end
        repeat (4) @(negedge clock);
        checks++; if (6'(rd0 - rs) !== 6'd2) begin errors++; $display("FAIL rst_mid_pops: got %0d expected 2", 6'(rd0 - rs)); end
    endtask

    task automatic test_parity_word();
        logic [43:0] line; int gap, dp, dc; bit ok;
        push0(8'h07);
        capture_frame(0, -1, line, gap, dp, dc, ok);
        checks++; if (!ok || line !== exp_line(8'h07)) begin errors++; $display("FAIL par_line: got ok=%b %h expected %h", ok, line, exp_line(8'h07)); end
        checks++; if (dp != FRAME_CYC - 1) begin errors++; $display("FAIL par_frame_len: got %0d expected %0d", dp + 1, FRAME_CYC); end
`ifdef UART_TX_PARITY_EN
        checks++; if (line[37] !== 1'b1) begin errors++; $display("FAIL par_bit: got %b expected 1", line[37]); end
`endif
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_empty_idle();
        test_enable_drop();
        test_reset_mid_frame();
        test_parity_word();
        checks++; if (underflow != 0) begin errors++; $display("FAIL underflow: got %0d expected 0", underflow); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
